// File: rtl/gate_resp_checker.sv
// In-circuit sweep checker: drives every N_IN-bit vector to a gate, samples its output after
// SETTLE cycles and compares it with a selectable truth table. GATECHK_FIRST_FAIL_EN adds capture.
module gate_resp_checker #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERR_W  = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      func_i,
  output logic [N_IN-1:0] vec_out_o,
  input  logic            dut_y_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [N_IN-1:0] fail_vec_o,
  output logic            fail_y_o
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] SettleM1 = CntW'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [2:0]       func_q, func_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic             exp_y, mismatch, sweep_start;

  always_comb begin
    exp_y = 1'b0;
    case (func_q)
      3'b000: exp_y = &vec_q;
      3'b001: exp_y = |vec_q;
      3'b010: exp_y = ~&vec_q;
      3'b011: exp_y = ~|vec_q;
      3'b100: exp_y = ^vec_q;
      3'b101: exp_y = ~^vec_q;
      3'b110: exp_y = vec_q[0];
      default: exp_y = ~vec_q[0];
    endcase
  end

  // X/Z on the gate output counts as a mismatch in simulation.
  assign mismatch = (state_q == StSample) && (dut_y_i !== exp_y);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_d       = vec_q;
    func_d      = func_q;
    err_d       = err_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    sweep_start = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          sweep_start = 1'b1;
          func_d      = func_i;
          vec_d       = '0;
          err_d       = '0;
          cnt_d       = SettleM1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          state_d     = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = StSample;
      end
      StSample: begin
        if (mismatch && (err_q != '1)) err_d = err_q + 1'b1;
        if (vec_q == '1) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          vec_d   = vec_q + 1'b1;
          cnt_d   = SettleM1;
          state_d = StSettle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      vec_q   <= '0;
      func_q  <= 3'b000;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      func_q  <= func_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign vec_out_o = vec_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign err_cnt_o = err_q;

`ifdef GATECHK_FIRST_FAIL_EN
  logic            fail_seen_q;
  logic [N_IN-1:0] fail_vec_q;
  logic            fail_y_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fail_seen_q <= 1'b0;
      fail_vec_q  <= '0;
      fail_y_q    <= 1'b0;
    end else if (sweep_start) begin
      fail_seen_q <= 1'b0;
      fail_vec_q  <= '0;
      fail_y_q    <= 1'b0;
    end else if (mismatch && !fail_seen_q) begin
      fail_seen_q <= 1'b1;
      fail_vec_q  <= vec_q;
      fail_y_q    <= dut_y_i;
    end
  end

  assign fail_vec_o = fail_vec_q;
  assign fail_y_o   = fail_y_q;
`else
  logic unused_start;
  assign unused_start = sweep_start;
  assign fail_vec_o   = '0;
  assign fail_y_o     = 1'b0;
`endif

endmodule

// File: tb/tb_gate_resp_checker.sv
// Directed bench for gate_resp_checker: default instance plus an N_IN=3/ERR_W=2 instance.
module tb_gate_resp_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic [2:0] func_a, func_b;
  logic [1:0] ymode_a, ymode_b;  // 0: tied low, 1: ideal AND, 2: ideal OR
  logic       y_a, y_b;

  logic [1:0] vec_a, fvec_a;
  logic       busy_a, done_a, pass_a, fy_a;
  logic [3:0] err_a;
  logic [2:0] vec_b, fvec_b;
  logic       busy_b, done_b, pass_b, fy_b;
  logic [1:0] err_b;

  int errors = 0;
  int checks = 0;
  int cyc;

  always #5 clk = ~clk;

  always_comb begin
    y_a = 1'b0;
    y_b = 1'b0;
    case (ymode_a)
      2'd1:    y_a = &vec_a;
      2'd2:    y_a = |vec_a;
      default: y_a = 1'b0;
    endcase
    case (ymode_b)
      2'd1:    y_b = &vec_b;
      2'd2:    y_b = |vec_b;
      default: y_b = 1'b0;
    endcase
  end

  gate_resp_checker u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .func_i(func_a), .vec_out_o(vec_a),
    .dut_y_i(y_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .err_cnt_o(err_a),
    .fail_vec_o(fvec_a), .fail_y_o(fy_a)
  );

  gate_resp_checker #(.N_IN(3), .SETTLE(2), .ERR_W(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .func_i(func_b), .vec_out_o(vec_b),
    .dut_y_i(y_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .err_cnt_o(err_b),
    .fail_vec_o(fvec_b), .fail_y_o(fy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dut_a(input logic [2:0] f, input logic [1:0] ym);
    func_a  = f;
    ymode_a = ym;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  // Counts edges until done_a rises; an expired budget shows up as a wrong cycle count.
  task automatic wait_done_a(output int n);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      n = i;
      if (done_a) break;
    end
  endtask

  initial begin
    logic [31:0] fv_exp3, fv_exp1;
`ifdef GATECHK_FIRST_FAIL_EN
    fv_exp3 = 3;
    fv_exp1 = 1;
`else
    fv_exp3 = 0;
    fv_exp1 = 0;
`endif
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    func_a = 3'b000; func_b = 3'b000; ymode_a = 2'd1; ymode_b = 2'd1;
    #12;
    chk("rst_vec", vec_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_fvec", fvec_a, 0);
    chk("rst_fy", fy_a, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Ideal AND: vectors step every 3 cycles, done at cycle 12.
    start_dut_a(3'b000, 2'd1);
    chk("and_busy0", busy_a, 1);
    chk("and_vec0", vec_a, 0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("and_vec_c%0d", k), vec_a, (k / 3 > 3) ? 3 : k / 3);
      chk($sformatf("and_done_c%0d", k), done_a, (k == 12) ? 1 : 0);
    end
    chk("and_pass", pass_a, 1);
    chk("and_err", err_a, 0);
    chk("and_busy_end", busy_a, 0);
    tick();
    chk("and_vec_hold", vec_a, 3);

    // AND with output tied low: only vector 3 fails.
    start_dut_a(3'b000, 2'd0);
    chk("tie0_done_drop", done_a, 0);
    chk("tie0_err_clr", err_a, 0);
    wait_done_a(cyc);
    chk("tie0_cycles", cyc, 12);
    chk("tie0_err", err_a, 1);
    chk("tie0_pass", pass_a, 0);
    chk("tie0_fvec", fvec_a, fv_exp3);
    chk("tie0_fy", fy_a, 0);

    // XOR against an AND gate: vectors 1,2,3 fail.
    start_dut_a(3'b100, 2'd1);
    wait_done_a(cyc);
    chk("xor_cycles", cyc, 12);
    chk("xor_err", err_a, 3);
    chk("xor_pass", pass_a, 0);
    chk("xor_fvec", fvec_a, fv_exp1);
    chk("xor_fy", fy_a, 0);

    // N_IN=3 NAND against AND: 8 mismatches saturate a 2-bit counter.
    func_b  = 3'b010;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      cyc = i;
      if (done_b) break;
    end
    chk("b_cycles", cyc, 24);
    chk("b_err_sat", err_b, 3);
    chk("b_pass", pass_b, 0);
    chk("b_vec", vec_b, 7);

    // Start pulse mid-sweep is ignored.
    start_dut_a(3'b000, 2'd1);
    for (int k = 1; k <= 4; k++) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("ign_busy", busy_a, 1);
    chk("ign_vec", vec_a, 1);
    wait_done_a(cyc);
    chk("ign_cycles_left", cyc, 7);
    chk("ign_pass", pass_a, 1);

    // Asynchronous reset mid-sweep, after one XOR mismatch has been counted.
    start_dut_a(3'b100, 2'd1);
    for (int k = 1; k <= 7; k++) tick();
    chk("pre_rst_err", err_a, 1);
    chk("pre_rst_vec", vec_a, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_vec", vec_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_err", err_a, 0);
    chk("arst_done", done_a, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_idle_busy", busy_a, 0);
    chk("post_rst_idle_vec", vec_a, 0);
    start_dut_a(3'b000, 2'd1);
    wait_done_a(cyc);
    chk("post_rst_cycles", cyc, 12);
    chk("post_rst_pass", pass_a, 1);
    chk("post_rst_err", err_a, 0);

    // Restart from DONE with OR after a failing sweep; func changed mid-sweep has no effect.
    start_dut_a(3'b100, 2'd1);
    wait_done_a(cyc);
    chk("pre_or_err", err_a, 3);
    start_dut_a(3'b001, 2'd2);
    chk("or_err_clr", err_a, 0);
    chk("or_done_drop", done_a, 0);
    chk("or_busy", busy_a, 1);
    func_a = 3'b111;
    wait_done_a(cyc);
    chk("or_cycles", cyc, 12);
    chk("or_err", err_a, 0);
    chk("or_pass", pass_a, 1);
    chk("or_fvec", fvec_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_resp_checker.md
Name: gate_resp_checker

Overview:
- Hardware-side counterpart to our gate stimulus benches: the block drives every input combination to a combinational gate under test, samples the gate output after a programmable settle time, and checks it against a selectable truth table.
- It counts mismatches and reports pass/fail, so gate cells (AND/OR/NAND/NOR/XOR/XNOR/INV) can be checked in-circuit without a simulator monitor.

Parameters:
- N_IN, 2, number of gate inputs driven (1..4); vector space is 2^N_IN.
- SETTLE, 2, clock cycles a vector is held before sampling (>=1).
- ERR_W, 4, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  one-cycle request to begin a sweep; ignored while busy.
- func  input  3  gate function; latched on accepted start. 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR (reduction), 101 XNOR, 110 BUF(in[0]), 111 INV(in[0]).
- vec_out  output  N_IN  registered input vector driven to the gate under test.
- dut_y  input  1  gate output being checked.
- busy  output  1  high from accepted start until done.
- done  output  1  high in DONE state; held until the next accepted start.
- pass  output  1  valid while done; 1 iff err_cnt==0.
- err_cnt  output  ERR_W  mismatch count, saturates at all-ones.
- fail_vec  output  N_IN  first failing vector (optional feature).
- fail_y  output  1  dut_y observed at first failure (optional feature).

Behaviour:
- Reset (async, immediate): state=IDLE; vec_out=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, fail_y=0; settle counter=0; latched func=000.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE + start=1:
  - Latch func, vec_out<=0, err_cnt<=0, clear fail capture, settle cnt<=SETTLE-1.
  - busy<=1, done<=0, pass<=0; go SETTLE.
- SETTLE:
  - cnt!=0: cnt--.
  - cnt==0: go SAMPLE.
  - Each vector therefore spends exactly SETTLE cycles in SETTLE.
- SAMPLE (1 cycle):
  - Compute expected from latched func and vec_out.
  - Mismatch (dut_y!=expected, including X/Z treated as mismatch in sim via !==): err_cnt<=err_cnt+1 unless already all-ones.
  - If vec_out==all-ones: go DONE, busy<=0, done<=1, pass<=(next err_cnt==0).
  - Else: vec_out<=vec_out+1, cnt<=SETTLE-1, go SETTLE.
- Latency: done rises exactly 2^N_IN*(SETTLE+1) cycles after the clock edge that accepts start (12 at defaults).
- vec_out changes only on the SAMPLE->SETTLE transition and on start; it holds its final value in DONE.
- start while busy: ignored; no restart, no counter change.
- start in DONE: immediate restart; done drops on the same edge.
- func changes mid-sweep: no effect (latched copy used).
- Reset mid-sweep: all state cleared asynchronously; a new start is required.
- N_IN=1: AND/OR/XOR reduce to in[0] (NAND/NOR/XNOR to ~in[0]).

Optional Feature:
- Macro GATECHK_FIRST_FAIL_EN.
- Defined: on the first mismatch of a sweep, fail_vec<=vec_out and fail_y<=dut_y; held until the next accepted start or reset. Later mismatches do not overwrite.
- Undefined: fail_vec and fail_y are constant 0; no capture registers are synthesized. Ports remain present.

Test Plan:
- Defaults, func=000, dut_y=&vec_out (ideal AND) -> vec_out steps 0,1,2,3 every 3 cycles; done at cycle 12 after start; pass=1, err_cnt=0.
- func=000, dut_y tied 0 -> err_cnt=1, pass=0; with macro, fail_vec=3, fail_y=0.
- func=100 (XOR), dut_y from ideal AND -> mismatches at vectors 1,2,3 -> err_cnt=3; with macro, fail_vec=1, fail_y=0.
- N_IN=3, ERR_W=2, func=010, dut_y from ideal AND (always wrong) -> 8 mismatches, err_cnt saturates at 3, pass=0, done at 24 cycles.
- Pulse start again at cycle 5 of a sweep -> ignored, done still at cycle 12; assert rst at cycle 7 -> all outputs 0 immediately, state IDLE; new start gives a full clean sweep.
- start asserted in DONE with func changed to 001 and dut_y=|vec_out -> counters cleared on that edge, new sweep passes with err_cnt=0.
